// File: rtl/spw_pkg.sv
// spw_pkg: character codes, field positions and read FSM states for the SpaceWire receive scheduler
package spw_pkg;
    localparam int LCHAR_BIT = 8;
    localparam logic [1:0] EOP_CODE = 2'b01;
    localparam logic [1:0] EEP_CODE = 2'b10;

    typedef enum logic [1:0] {IDLE, WAIT, HOLD} rx_state_t;

    function automatic logic is_eop(input logic [8:0] c);
        return c[LCHAR_BIT] && c[1:0] == EOP_CODE;
    endfunction

    function automatic logic is_eep(input logic [8:0] c);
        return c[LCHAR_BIT] && c[1:0] == EEP_CODE;
    endfunction
endpackage

// File: rtl/spw_fct_credit.sv
// spw_fct_credit: queue occupancy, peer credit and FCT request generation
module spw_fct_credit #(
    parameter int DEPTH = 8,
    parameter int CREDIT_BLK = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic q_we_i,
    input  logic q_ack_i,
    input  logic link_up_i,
    input  logic fct_ack_i,
    output logic fct_req_o,
    output logic credit_err_o
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = CW + 2;
    logic [CW-1:0] occ;
    logic [CW-1:0] cred;
    logic grant;
    logic [SW-1:0] room;
    assign grant = fct_req_o & fct_ack_i;
    assign room = SW'(occ) + SW'(cred) + SW'(CREDIT_BLK);
    // occupancy always tracks the queue; credit state only lives while the link runs
    always_ff @(posedge clk) begin
        if (!reset) begin
            occ <= '0;
            cred <= '0;
            fct_req_o <= 1'b0;
            credit_err_o <= 1'b0;
        end else begin
            occ <= occ + CW'(q_we_i) - CW'(q_ack_i);
            if (!link_up_i) begin
                cred <= '0;
                fct_req_o <= 1'b0;
                credit_err_o <= 1'b0;
            end else begin
                cred <= cred + (grant ? CW'(CREDIT_BLK) : '0) - ((q_we_i && (cred != '0 || grant)) ? CW'(1) : '0);
                credit_err_o <= credit_err_o | (q_we_i & (cred == '0) & ~grant);
                fct_req_o <= fct_req_o ? ~fct_ack_i : (room <= SW'(DEPTH));
            end
        end
    end
endmodule

// File: rtl/spw_rx_sched.sv
// spw_rx_sched: pops the receive queue, delivers characters over valid/ready and tracks packets and credit
module spw_rx_sched import spw_pkg::*; #(
    parameter int DEPTH = 8,
    parameter int CREDIT_BLK = 8,
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [8:0]       q_dat_i,
    input  logic             q_empty_i,
    input  logic             q_ack_i,
    input  logic             q_we_i,
    output logic             q_stb_o,
    input  logic             link_up_i,
    output logic [7:0]       dat_o,
    output logic             eop_o,
    output logic             eep_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic             pkt_done_o,
    output logic [LEN_W-1:0] pkt_len_o,
    output logic             pkt_err_o,
    output logic             fct_req_o,
    input  logic             fct_ack_i,
    output logic             credit_err_o
);
    rx_state_t state;
    logic [8:0] hold;
    logic [LEN_W-1:0] len_cnt;
    logic fire;
    assign fire = state == HOLD && ready_i;
    assign q_stb_o = reset && state == IDLE && !q_empty_i;
    assign valid_o = state == HOLD;
    assign dat_o = hold[7:0];
    assign eop_o = is_eop(hold);
    assign eep_o = is_eep(hold);
    // read path: one pop per IDLE visit, head latched as it is popped
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            hold <= '0;
        end else begin
            case (state)
                IDLE: if (!q_empty_i) begin
                    hold <= q_dat_i;
                    state <= WAIT;
                end
                WAIT: if (q_ack_i) state <= HOLD;
                HOLD: if (ready_i) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
    // packet length and completion status, advanced on each delivered character
    always_ff @(posedge clk) begin
        if (!reset) begin
            len_cnt <= '0;
            pkt_done_o <= 1'b0;
            pkt_len_o <= '0;
            pkt_err_o <= 1'b0;
        end else begin
            pkt_done_o <= fire & hold[LCHAR_BIT];
            if (fire && hold[LCHAR_BIT]) begin
                pkt_len_o <= len_cnt;
                pkt_err_o <= is_eep(hold);
                len_cnt <= '0;
            end else if (fire) begin
                len_cnt <= len_cnt + LEN_W'(len_cnt != '1);
            end
        end
    end

    spw_fct_credit #(.DEPTH(DEPTH), .CREDIT_BLK(CREDIT_BLK)) u_credit (
        .clk(clk),
        .reset(reset),
        .q_we_i(q_we_i),
        .q_ack_i(q_ack_i),
        .link_up_i(link_up_i),
        .fct_ack_i(fct_ack_i),
        .fct_req_o(fct_req_o),
        .credit_err_o(credit_err_o)
    );
endmodule

// File: tb/tb_spw_rx_sched.sv
// tb_spw_rx_sched: scoreboard bench with a behavioural queue model
module tb_spw_rx_sched;
    import spw_pkg::*;
    logic clk = 0;
    logic reset = 0;
    logic [8:0] q_dat_i;
    logic q_empty_i, q_ack_i;
    logic q_we_i = 0;
    logic q_stb_o;
    logic link_up_i = 1;
    logic [7:0] dat_o;
    logic eop_o, eep_o, valid_o;
    logic ready_i = 1;
    logic pkt_done_o;
    logic [15:0] pkt_len_o;
    logic pkt_err_o, fct_req_o;
    logic fct_ack_i = 0;
    logic credit_err_o;

    logic [8:0] wr_dat = 0;
    logic [8:0] fifo[$];
    logic [9:0] exp_q[$];
    logic [16:0] pkt_q[$];
    logic pend = 0;
    logic ack_en = 1;
    int pcnt = 0;
    int stb_cnt = 0;
    int pass_cnt = 0;
    int chk_cnt = 0;

    always #5 clk = ~clk;

    spw_rx_sched dut (
        .clk(clk), .reset(reset), .q_dat_i(q_dat_i), .q_empty_i(q_empty_i), .q_ack_i(q_ack_i),
        .q_we_i(q_we_i), .q_stb_o(q_stb_o), .link_up_i(link_up_i), .dat_o(dat_o), .eop_o(eop_o),
        .eep_o(eep_o), .valid_o(valid_o), .ready_i(ready_i), .pkt_done_o(pkt_done_o),
        .pkt_len_o(pkt_len_o), .pkt_err_o(pkt_err_o), .fct_req_o(fct_req_o), .fct_ack_i(fct_ack_i),
        .credit_err_o(credit_err_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic fail(input string name);
        chk_cnt++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // behavioural 9-bit queue: ack follows stb by one cycle unless held off
    initial begin
        logic stb_s, we_s, ack_s, rst_s;
        logic [8:0] wd_s;
        q_ack_i = 0;
        q_empty_i = 1;
        q_dat_i = 0;
        forever begin
            @(negedge clk);
            stb_s = q_stb_o; we_s = q_we_i; wd_s = wr_dat; ack_s = q_ack_i; rst_s = reset;
            @(posedge clk);
            #1;
            if (!rst_s) begin
                fifo.delete();
                pend = 0;
                q_ack_i = 0;
            end else begin
                if (ack_s && fifo.size() > 0) void'(fifo.pop_front());
                if (we_s) fifo.push_back(wd_s);
                pend = pend | stb_s;
                q_ack_i = pend & ack_en;
                if (q_ack_i) pend = 0;
            end
            q_empty_i = fifo.size() == 0;
            q_dat_i = (fifo.size() > 0) ? fifo[0] : 9'h000;
        end
    end

    // monitor: compares delivered characters and packet completions against the scoreboard
    initial forever begin
        @(negedge clk);
        if (reset) begin
            if (q_stb_o) stb_cnt++;
            if (valid_o) begin
                if (exp_q.size() == 0) fail("unexpected_char");
                else begin
                    check("char", 32'({eop_o, eep_o, dat_o}), 32'(exp_q[0]));
                    if (ready_i) void'(exp_q.pop_front());
                end
            end
            if (pkt_done_o) begin
                if (pkt_q.size() == 0) fail("unexpected_pkt_done");
                else check("pkt_err_len", 32'({pkt_err_o, pkt_len_o}), 32'(pkt_q.pop_front()));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [8:0] c);
        q_we_i = 1;
        wr_dat = c;
        if (!c[8]) begin
            exp_q.push_back({2'b00, c[7:0]});
            pcnt++;
        end else begin
            exp_q.push_back({c[1:0] == 2'b01, c[1:0] == 2'b10, c[7:0]});
            pkt_q.push_back({c[1:0] == 2'b10, 16'(pcnt)});
            pcnt = 0;
        end
        step();
        q_we_i = 0;
    endtask

    task automatic grant(input int lim);
        int n = 0;
        while (!fct_req_o && n < lim) begin
            @(negedge clk);
            n++;
        end
        check("fct_req_up", 32'(fct_req_o), 1);
        fct_ack_i = 1;
        step();
        fct_ack_i = 0;
        @(negedge clk);
        check("cred_after_grant", 32'(dut.u_credit.cred), 8);
        check("fct_req_after_grant", 32'(fct_req_o), 0);
    endtask

    task automatic relink();
        step();
        link_up_i = 0;
        step();
        link_up_i = 1;
        grant(4);
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!valid_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("valid_timeout", 32'(valid_o), 1);
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || pkt_q.size() != 0 || valid_o) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", 32'(n < 300), 1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", 32'(valid_o), 0);
        check("rst_stb", 32'(q_stb_o), 0);
        check("rst_fct_req", 32'(fct_req_o), 0);
        check("rst_pkt", 32'({pkt_done_o, pkt_err_o, pkt_len_o}), 0);
        check("rst_cerr", 32'(credit_err_o), 0);
        step();
        reset = 1;
        grant(2);
        repeat (3) begin
            @(negedge clk);
            check("fct_req_idle", 32'(fct_req_o), 0);
        end
        // packet 41 42 EOP
        step();
        stb_cnt = 0;
        put(9'h041);
        put(9'h042);
        put(9'h101);
        drain();
        check("stb_pulses_eop", 32'(stb_cnt), 3);
        check("cred_5", 32'(dut.u_credit.cred), 5);
        // link drop with pending characters
        step();
        ready_i = 0;
        link_up_i = 0;
        step();
        @(negedge clk);
        check("linkdn_cred", 32'(dut.u_credit.cred), 0);
        check("linkdn_fct_req", 32'(fct_req_o), 0);
        step();
        put(9'h055);
        put(9'h101);
        ready_i = 1;
        drain();
        check("linkdn_cerr", 32'(credit_err_o), 0);
        step();
        link_up_i = 1;
        grant(4);
        // packet 41 42 EEP with a 5 cycle stall on the second character
        step();
        stb_cnt = 0;
        ready_i = 0;
        put(9'h041);
        put(9'h042);
        put(9'h102);
        wait_valid();
        step();
        ready_i = 1;
        step();
        ready_i = 0;
        wait_valid();
        repeat (5) @(negedge clk);
        check("stall_dat", 32'(dat_o), 32'h42);
        step();
        ready_i = 1;
        drain();
        check("stb_pulses_eep", 32'(stb_cnt), 3);
        relink();
        // fill all credit without reads, then drain
        step();
        ack_en = 0;
        for (int i = 0; i < 8; i++) put(9'(8'h10 + i));
        @(negedge clk);
        check("full_occ", 32'(dut.u_credit.occ), 8);
        check("full_cred", 32'(dut.u_credit.cred), 0);
        check("full_fct_req", 32'(fct_req_o), 0);
        ack_en = 1;
        drain();
        check("drained_occ", 32'(dut.u_credit.occ), 0);
        check("drained_fct_req", 32'(fct_req_o), 1);
        step();
        put(9'h018);
        @(negedge clk);
        check("credit_err", 32'(credit_err_o), 1);
        drain();
        // reset while holding a character
        step();
        ready_i = 0;
        put(9'h077);
        wait_valid();
        step();
        reset = 0;
        exp_q.delete();
        pkt_q.delete();
        pcnt = 0;
        @(posedge clk);
        @(negedge clk);
        check("hold_rst_valid", 32'(valid_o), 0);
        check("hold_rst_stb", 32'(q_stb_o), 0);
        check("hold_rst_len", 32'(pkt_len_o), 0);
        check("hold_rst_state", 32'(dut.state), 32'(IDLE));
        check("hold_rst_cerr", 32'(credit_err_o), 0);
        step();
        reset = 1;
        ready_i = 1;
        repeat (4) @(negedge clk);
        check("post_rst_valid", 32'(valid_o), 0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
